// File: rtl/tick_sequencer.sv
// Game-tick scheduler: one direction-exchange/move/collide/point/commit pass per divided-clock tick.
// Optional build macro TICK_SEQ_STATS_EN enables the saturating dropped-tick counter.
module tick_sequencer #(
  parameter int unsigned RX_TIMEOUT   = 2_000_000,
  parameter int unsigned STEP_TIMEOUT = 1024,
  parameter int unsigned ModeW        = 2,
  parameter logic [ModeW-1:0] ModeGame = ModeW'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [ModeW-1:0] mode,
  input  logic             rcvdir,
  input  logic             move_done,
  input  logic             col_done,
  input  logic             eaten,
  input  logic             seed_rdy,
  output logic             send_dir,
  output logic             move_start,
  output logic             col_start,
  output logic             point_start,
  output logic             commit,
  output logic             con_error,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);

  localparam int unsigned WdW = $clog2(RX_TIMEOUT);
  localparam logic [WdW-1:0] RxLast   = WdW'(RX_TIMEOUT - 1);
  localparam logic [WdW-1:0] StepLast = WdW'(STEP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StSend, StWaitRx, StMove, StCollide, StPoint, StCommit, StError
  } state_e;

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           tick_q, pend_q, pend_d;
  logic           send_q, move_q, col_q, point_q, commit_q, err_q;
  logic           in_game, tick_edge, entry;

  assign in_game   = (mode == ModeGame);
  assign tick_edge = tick & ~tick_q;

  always_comb begin
    state_d = state_q;
    if (!in_game) begin
      // Leaving GAME aborts from any state, ahead of every acknowledge.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    if (tick_edge) state_d = StSend;
        StSend:    state_d = pend_q ? StMove : StWaitRx;
        StWaitRx: begin
          if (rcvdir)              state_d = StMove;
          else if (wd_q == RxLast) state_d = StError;
        end
        StMove: begin
          if (move_done)             state_d = StCollide;
          else if (wd_q == StepLast) state_d = StError;
        end
        StCollide: begin
          if (col_done)              state_d = eaten ? StPoint : StCommit;
          else if (wd_q == StepLast) state_d = StError;
        end
        StPoint: begin
          if (seed_rdy)              state_d = StCommit;
          else if (wd_q == StepLast) state_d = StError;
        end
        StCommit:  state_d = StIdle;
        StError:   state_d = StError;
        default:   state_d = StIdle;
      endcase
    end
  end

  assign entry = (state_d != state_q);
  assign wd_d  = entry ? '0 : wd_q + 1'b1;

  // Remote direction that beat the tick is remembered so SEND can skip WAIT_RX.
  always_comb begin
    pend_d = pend_q;
    if (!in_game)                          pend_d = 1'b0;
    else if (state_q == StSend)            pend_d = 1'b0;
    else if (state_q == StIdle && rcvdir)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wd_q     <= '0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
      send_q   <= 1'b0;
      move_q   <= 1'b0;
      col_q    <= 1'b0;
      point_q  <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      tick_q   <= tick;
      pend_q   <= pend_d;
      send_q   <= entry && (state_d == StSend);
      move_q   <= entry && (state_d == StMove);
      col_q    <= entry && (state_d == StCollide);
      point_q  <= entry && (state_d == StPoint);
      commit_q <= entry && (state_d == StCommit);
      err_q    <= (state_d == StError);
    end
  end

  assign send_dir    = send_q;
  assign move_start  = move_q;
  assign col_start   = col_q;
  assign point_start = point_q;
  assign commit      = commit_q;
  assign con_error   = err_q;
  assign busy        = (state_q != StIdle);

`ifdef TICK_SEQ_STATS_EN
  logic       game_q;
  logic [7:0] ovr_q;
  logic       dropped;

  assign dropped = tick_edge && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_q <= 1'b0;
      ovr_q  <= '0;
    end else begin
      game_q <= in_game;
      if (in_game && !game_q)               ovr_q <= '0;
      else if (dropped && ovr_q != 8'hFF)   ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: per-cycle vector table plus timeout, overrun and reset sequences.
module tb_tick_sequencer;

  localparam logic [1:0] Game = 2'd1;
  localparam logic [1:0] Menu = 2'd0;
`ifdef TICK_SEQ_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, rcvdir = 1'b0, move_done = 1'b0, col_done = 1'b0;
  logic       eaten = 1'b0, seed_rdy = 1'b0;
  logic [1:0] mode = Game;
  logic       send_dir, move_start, col_start, point_start, commit, con_error, busy;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int failures = 0;

  tick_sequencer #(
    .RX_TIMEOUT   (100),
    .STEP_TIMEOUT (16),
    .ModeW        (2),
    .ModeGame     (Game)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .mode        (mode),
    .rcvdir      (rcvdir),
    .move_done   (move_done),
    .col_done    (col_done),
    .eaten       (eaten),
    .seed_rdy    (seed_rdy),
    .send_dir    (send_dir),
    .move_start  (move_start),
    .col_start   (col_start),
    .point_start (point_start),
    .commit      (commit),
    .con_error   (con_error),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  // in  = {tick, game, rcvdir, move_done, col_done, eaten, seed_rdy}
  // out = {send_dir, move_start, col_start, point_start, commit, busy, con_error}
  typedef struct {
    logic [6:0] in;
    logic [6:0] out;
    int         ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [6:0] i, input logic [6:0] o, input int ov = 0);
    vec_t v;
    v.in  = i;
    v.out = o;
    v.ovr = ov;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       g;
    logic [6:0] outs;
    int         sends;
    logic       seen_ms;

    // Basic tick, no food
    add(7'b1100000, 7'b1000010);
    add(7'b1100000, 7'b0000010);
    add(7'b0100000, 7'b0000010);
    add(7'b0110000, 7'b0100010);
    add(7'b0100000, 7'b0000010);
    add(7'b0101000, 7'b0010010);
    add(7'b0100000, 7'b0000010);
    add(7'b0100100, 7'b0000110);
    add(7'b0100000, 7'b0000000);
    add(7'b0100000, 7'b0000000);
    // Food eaten, stray acks ignored, seed_rdy 3 cycles after point_start
    add(7'b1100000, 7'b1000010);
    add(7'b0101000, 7'b0000010);
    add(7'b0110000, 7'b0100010);
    add(7'b0101000, 7'b0010010);
    add(7'b0100110, 7'b0001010);
    add(7'b0100000, 7'b0000010);
    add(7'b0100100, 7'b0000010);
    add(7'b0100000, 7'b0000010);
    add(7'b0100001, 7'b0000110);
    add(7'b0100000, 7'b0000000);
    // Early rcvdir in IDLE
    add(7'b0110000, 7'b0000000);
    add(7'b1100000, 7'b1000010);
    add(7'b1100000, 7'b0100010);
    add(7'b1101000, 7'b0010010);
    add(7'b1100100, 7'b0000110);
    add(7'b1100000, 7'b0000000);
    // Minimum latency: rcvdir during SEND is not latched
    add(7'b0100000, 7'b0000000);
    add(7'b1100000, 7'b1000010);
    add(7'b0110000, 7'b0000010);
    add(7'b0110000, 7'b0100010);
    add(7'b0101000, 7'b0010010);
    add(7'b0100100, 7'b0000110);
    add(7'b0100000, 7'b0000000);
    // Abort in COLLIDE, abort beats col_done; tick outside GAME ignored
    add(7'b0100000, 7'b0000000);
    add(7'b1100000, 7'b1000010);
    add(7'b0100000, 7'b0000010);
    add(7'b0110000, 7'b0100010);
    add(7'b0101000, 7'b0010010);
    add(7'b0000100, 7'b0000000);
    add(7'b0100000, 7'b0000000);
    add(7'b1000000, 7'b0000000);
    add(7'b1100000, 7'b0000000);
    add(7'b0100000, 7'b0000000);
    // Overrun: second tick edge in MOVE is dropped
    add(7'b1100000, 7'b1000010);
    add(7'b0100000, 7'b0000010);
    add(7'b0110000, 7'b0100010);
    add(7'b1100000, 7'b0000010, 1);
    add(7'b0101000, 7'b0010010, 1);
    add(7'b0100100, 7'b0000110, 1);
    add(7'b0100000, 7'b0000000, 1);

    #1;
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {send_dir, move_start, col_start, point_start, commit}, 0);
    chk("reset_err", con_error, 0);
    chk("reset_ovr", overrun_cnt, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_reset_busy", busy, 0);

    foreach (vecs[i]) begin
      {tick, g, rcvdir, move_done, col_done, eaten, seed_rdy} = vecs[i].in;
      mode = g ? Game : Menu;
      step();
      outs = {send_dir, move_start, col_start, point_start, commit, busy, con_error};
      chk($sformatf("vec%0d_out", i), outs, vecs[i].out);
      chk($sformatf("vec%0d_ovr", i), overrun_cnt, Stats ? vecs[i].ovr : 0);
    end
    {tick, rcvdir, move_done, col_done, eaten, seed_rdy} = '0;
    mode = Game;
    step();

    // RX timeout: error exactly 100 cycles after WAIT_RX entry
    tick = 1'b1;
    step();
    chk("rx_send", send_dir, 1);
    tick = 1'b0;
    step();
    seen_ms = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (move_start) seen_ms = 1'b1;
      if (k == 99) chk("rx_err_early", con_error, 0);
    end
    chk("rx_err", con_error, 1);
    chk("rx_no_move", seen_ms, 0);
    chk("rx_err_busy", busy, 1);
    mode = Menu;
    step();
    chk("rx_err_clear", con_error, 0);
    chk("rx_idle", busy, 0);
    mode = Game;
    step();

    // Step watchdog in MOVE
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rcvdir = 1'b1;
    step();
    rcvdir = 1'b0;
    chk("step_move_start", move_start, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) chk("step_err_early", con_error, 0);
    end
    chk("step_err", con_error, 1);
    mode = Menu;
    step();
    mode = Game;
    step();
    chk("step_cleared", con_error, 0);

    // 300 dropped edges saturate the counter and never retrigger SEND
    tick = 1'b1;
    step();
    chk("ovr_send", send_dir, 1);
    tick = 1'b0;
    step();
    sends = 0;
    for (int i = 0; i < 300; i++) begin
      tick = 1'b1;
      step();
      sends += int'(send_dir);
      if (i == 0) chk("ovr_first", overrun_cnt, Stats ? 1 : 0);
      tick = 1'b0;
      step();
      sends += int'(send_dir);
    end
    chk("ovr_no_send", sends, 0);
    chk("ovr_sat", overrun_cnt, Stats ? 255 : 0);
    chk("ovr_busy", busy, 1);
    mode = Menu;
    step();
    mode = Game;
    step();
    chk("ovr_clear_on_game", overrun_cnt, 0);

    // Asynchronous reset in the middle of POINT
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rcvdir = 1'b1;
    step();
    rcvdir = 1'b0;
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    col_done = 1'b1;
    eaten = 1'b1;
    step();
    col_done = 1'b0;
    eaten = 1'b0;
    chk("rst_point_start", point_start, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outs", {send_dir, move_start, col_start, point_start, commit, busy, con_error}, 0);
    chk("rst_async_ovr", overrun_cnt, 0);
    #1;
    rst = 1'b1;
    step();
    chk("rst_release_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
